dtc_tree_walker: RTL

//  Sequential, table-driven decision-tree classifier; successor to the fixed combinational dtc_* trees.

---
 rtl/dtc_pkg.sv | 22 ++
 rtl/dtc_node_ram.sv | 23 ++
 rtl/dtc_tree_walker.sv | 128 ++++++++++++
 3 files changed

// File: rtl/dtc_pkg.sv
// Shared types and default sizing for the table-driven decision-tree walker.
package dtc_pkg;

  localparam int unsigned DTC_N_FEAT    = 12;
  localparam int unsigned DTC_CLASS_W   = 3;
  localparam int unsigned DTC_N_NODES   = 512;
  localparam int unsigned DTC_MAX_DEPTH = 16;
  localparam int unsigned DTC_FEAT_W    = $clog2(DTC_N_FEAT);
  localparam int unsigned DTC_ADDR_W    = $clog2(DTC_N_NODES);
  localparam int unsigned DTC_NODE_W    = 1 + DTC_FEAT_W + 2 * DTC_ADDR_W;

  // Node word layout for the default sizing; leaves carry their class in f_ptr.
  typedef struct packed {
    logic                  is_leaf;
    logic [DTC_FEAT_W-1:0] feat_idx;
    logic [DTC_ADDR_W-1:0] t_ptr;
    logic [DTC_ADDR_W-1:0] f_ptr;
  } node_t;

  typedef enum logic [1:0] {IDLE, WALK, DONE} state_t;

endpackage

// File: rtl/dtc_node_ram.sv
// Single-port node table with synchronous read; contents are never reset.
module dtc_node_ram
  import dtc_pkg::*;
#(
  parameter  int unsigned DEPTH  = DTC_N_NODES,
  parameter  int unsigned WIDTH  = DTC_NODE_W,
  localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/dtc_tree_walker.sv
// Sequential decision-tree classifier: walks one node per clock from the root
// to a leaf and returns the class over a valid/ready pair.
module dtc_tree_walker
  import dtc_pkg::*;
#(
  parameter  int unsigned N_FEAT    = DTC_N_FEAT,
  parameter  int unsigned CLASS_W   = DTC_CLASS_W,
  parameter  int unsigned N_NODES   = DTC_N_NODES,
  parameter  int unsigned MAX_DEPTH = DTC_MAX_DEPTH,
  localparam int unsigned FEAT_W    = $clog2(N_FEAT),
  localparam int unsigned ADDR_W    = $clog2(N_NODES),
  localparam int unsigned NODE_W    = 1 + FEAT_W + 2 * ADDR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_FEAT-1:0]  in_feat,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CLASS_W-1:0] out_class,
  output logic               out_err,
  input  logic               cfg_we,
  input  logic [ADDR_W-1:0]  cfg_addr,
  input  logic [NODE_W-1:0]  cfg_wdata,
  output logic               cfg_err
);

  localparam int unsigned          DEPTH_W    = $clog2(MAX_DEPTH + 1);
  localparam logic [DEPTH_W-1:0]   DEPTH_MAX  = DEPTH_W'(MAX_DEPTH);
  localparam logic [FEAT_W:0]      FEAT_LIMIT = (FEAT_W + 1)'(N_FEAT);

  typedef struct packed {
    logic              is_leaf;
    logic [FEAT_W-1:0] feat_idx;
    logic [ADDR_W-1:0] t_ptr;
    logic [ADDR_W-1:0] f_ptr;
  } walk_node_t;

  state_t             state, state_nxt;
  logic [N_FEAT-1:0]  feat_q;
  logic [DEPTH_W-1:0] depth;
  logic [CLASS_W-1:0] class_q;
  logic               err_q;
  logic               cfg_err_q;

  logic               accept;
  logic               ram_we;
  logic [ADDR_W-1:0]  ram_addr;
  logic [NODE_W-1:0]  ram_rdata;
  walk_node_t         node;
  logic               node_abort;
  logic [ADDR_W-1:0]  next_ptr;

  dtc_node_ram #(
    .DEPTH (N_NODES),
    .WIDTH (NODE_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (cfg_wdata),
    .rdata (ram_rdata)
  );

  assign node = walk_node_t'(ram_rdata);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = WALK;
      WALK:    if (node.is_leaf || node_abort) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = accept ? WALK : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Node RAM shares one port between config writes and the walk; writes win
  // only in IDLE with no accept, so the walk never sees a conflicting cycle.
  always_comb begin
    in_ready   = (state == IDLE) || ((state == DONE) && out_ready);
    out_valid  = (state == DONE);
    accept     = in_valid && in_ready;
    node_abort = !node.is_leaf &&
                 (({1'b0, node.feat_idx} >= FEAT_LIMIT) || (depth == DEPTH_MAX));
    next_ptr   = feat_q[node.feat_idx] ? node.t_ptr : node.f_ptr;
    ram_we     = cfg_we && (state == IDLE) && !accept;
    ram_addr   = '0;
    if (ram_we)              ram_addr = cfg_addr;
    else if (state == WALK)  ram_addr = next_ptr;
    out_class  = class_q;
    out_err    = err_q;
    cfg_err    = cfg_err_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      feat_q    <= '0;
      depth     <= '0;
      class_q   <= '0;
      err_q     <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_we && !ram_we;
      if (accept) begin
        feat_q <= in_feat;
        depth  <= DEPTH_W'(1);
      end else if ((state == WALK) && !node.is_leaf && !node_abort) begin
        depth <= depth + DEPTH_W'(1);
      end
      if (state == WALK) begin
        if (node.is_leaf) begin
          class_q <= node.f_ptr[CLASS_W-1:0];
          err_q   <= 1'b0;
        end else if (node_abort) begin
          class_q <= '0;
          err_q   <= 1'b1;
        end
      end
    end
  end

endmodule
